// File: rtl/pcm_uart_tx.sv
// PCM sample serializer: one-entry holding buffer feeding an 8N1 (or 8E1) UART
// transmitter. All outputs are registered so the serial line never glitches.
module pcm_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       txd,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_par, w_par_nxt;
    logic [7:0]  r_buf_data, w_buf_data_nxt;
    logic        r_buf_full, w_buf_full_nxt;
    logic        r_ready;
    logic        r_txd, w_txd_nxt;
    logic        r_busy;
    logic        r_overrun;
    logic        w_tick;
    logic        w_load;
    logic        w_accept;

    assign w_tick   = (r_cnt == LP_LAST);
    assign w_accept = data_valid & r_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = (r_state == S_IDLE || w_tick) ? 16'd0 : r_cnt + 16'd1;
        w_idx_nxt      = r_idx;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_buf_data_nxt = r_buf_data;
        w_buf_full_nxt = r_buf_full;
        w_load         = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (r_buf_full) w_load = 1'b1;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_par_nxt   = r_par ^ r_shift[0];
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7)
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_buf_full) w_load = 1'b1;
                    else            w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Load and accept are mutually exclusive: load needs a full buffer,
        // accept needs an empty one.
        if (w_load) begin
            w_state_nxt    = S_START;
            w_shift_nxt    = r_buf_data;
            w_par_nxt      = 1'b0;
            w_cnt_nxt      = 16'd0;
            w_buf_full_nxt = 1'b0;
        end
        if (w_accept) begin
            w_buf_data_nxt = data_in;
            w_buf_full_nxt = 1'b1;
        end

        unique case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
            S_PARITY: w_txd_nxt = w_par_nxt;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_idx      <= 3'd0;
            r_shift    <= 8'd0;
            r_par      <= 1'b0;
            r_buf_data <= 8'd0;
            r_buf_full <= 1'b0;
            r_ready    <= 1'b1;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_buf_data <= w_buf_data_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_ready    <= ~w_buf_full_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_overrun  <= data_valid & ~r_ready;
        end
    end

    assign data_ready = r_ready;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pcm_uart_tx.sv
// Bench for pcm_uart_tx: three configurations, a timing model of buffer and
// frame occupancy, and a line deserializer that checks frames against a queue.
module tb_pcm_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       dv     [3];
    logic [7:0] din    [3];
    logic       rdy    [3];
    logic       txd_o  [3];
    logic       busy_o [3];
    logic       ovr_o  [3];

    pcm_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_a (
        .clk(clk), .reset(rst_n), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .txd(txd_o[0]), .busy(busy_o[0]), .overrun(ovr_o[0]));
    pcm_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_b (
        .clk(clk), .reset(rst_n), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .txd(txd_o[1]), .busy(busy_o[1]), .overrun(ovr_o[1]));
    pcm_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) u_c (
        .clk(clk), .reset(rst_n), .data_in(din[2]), .data_valid(dv[2]),
        .data_ready(rdy[2]), .txd(txd_o[2]), .busy(busy_o[2]), .overrun(ovr_o[2]));

    int sel = 0;
    int cpb = 4;
    int par_en = 0;
    logic w_txd;
    assign w_txd = txd_o[sel];

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: edge counter, buffer occupancy, current frame window.
    int         e = 0;
    int         tx_end = 0;
    int         frame_l = 0;
    int         accepted = 0;
    logic       m_full = 1'b0;
    logic [7:0] m_buf = 8'd0;
    logic [7:0] f_byte = 8'd0;
    logic       exp_ovr = 1'b0;
    logic [7:0] q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int pos, input int pe);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pe != 0 && pos == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic cyc(input logic v, input logic [7:0] d);
        logic full_pre;
        for (int k = 0; k < 3; k++) begin
            dv[k]  = 1'b0;
            din[k] = 8'd0;
        end
        dv[sel]  = v;
        din[sel] = d;
        @(posedge clk);
        full_pre = m_full;
        e++;
        if (full_pre && e >= tx_end) begin
            frame_l = e;
            f_byte  = m_buf;
            tx_end  = e + cpb * ((par_en != 0) ? 11 : 10);
            m_full  = 1'b0;
        end
        if (v && !full_pre) begin
            m_full = 1'b1;
            m_buf  = d;
            q.push_back(d);
            accepted++;
        end
        exp_ovr = v && full_pre;
        #1;
        chk("data_ready", rdy[sel], !m_full);
        chk("overrun", ovr_o[sel], exp_ovr);
        chk("busy", busy_o[sel], e < tx_end);
        if (e < tx_end)
            chk("txd", txd_o[sel], frame_bit(f_byte, (e - frame_l) / cpb, par_en));
        else
            chk("txd_idle", txd_o[sel], 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(e >= tx_end && !m_full && q.size() == 0) && n < 400) begin
            cyc(1'b0, 8'd0);
            n++;
        end
        chk("drain_timeout", n < 400, 1);
        repeat (3) cyc(1'b0, 8'd0);
    endtask

    task automatic set_cfg(input int s, input int c, input int p);
        sel    = s;
        cpb    = c;
        par_en = p;
        m_full = 1'b0;
        tx_end = e;
    endtask

    // Monitor: deserializes the selected line mid-bit and scores each frame.
    initial begin
        logic       prev, st, pb, sb, ab;
        logic [7:0] rx, ex;
        int         c, pe;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
            end else if (prev && !w_txd) begin
                c  = cpb;
                pe = par_en;
                ab = 1'b0;
                repeat (c / 2) @(negedge clk);
                st = w_txd; ab |= !rst_n;
                for (int i = 0; i < 8; i++) begin
                    repeat (c) @(negedge clk);
                    rx[i] = w_txd; ab |= !rst_n;
                end
                pb = 1'b0;
                if (pe != 0) begin
                    repeat (c) @(negedge clk);
                    pb = w_txd; ab |= !rst_n;
                end
                repeat (c) @(negedge clk);
                sb = w_txd; ab |= !rst_n;
                if (!ab) begin
                    chk("start_bit", st, 0);
                    chk("stop_bit", sb, 1);
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0h expected no frame", rx);
                    end else begin
                        ex = q.pop_front();
                        chk("rx_data", rx, ex);
                        if (pe != 0) chk("parity_bit", pb, ^ex);
                    end
                end
                prev = w_txd;
            end else begin
                prev = w_txd;
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dv[k]  = 1'b0;
            din[k] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", rdy[k], 1);
            chk("rst_txd", txd_o[k], 1);
            chk("rst_busy", busy_o[k], 0);
            chk("rst_overrun", ovr_o[k], 0);
        end
        #2 rst_n = 1'b1;

        // Single frame, then back-to-back frames with a dropped third sample.
        set_cfg(0, 4, 0);
        cyc(1'b1, 8'hA5);
        wait_idle();
        cyc(1'b1, 8'h11);
        repeat (5) cyc(1'b0, 8'd0);
        cyc(1'b1, 8'h22);
        repeat (3) cyc(1'b0, 8'd0);
        cyc(1'b1, 8'h33);
        wait_idle();

        // Abort during data bit 3, then a clean frame.
        cyc(1'b1, 8'h5A);
        n = 0;
        while (!(e < tx_end && (e - frame_l) == 4 * cpb + 1) && n < 100) begin
            cyc(1'b0, 8'd0);
            n++;
        end
        chk("bit3_timeout", n < 100, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_txd", txd_o[0], 1);
        chk("abort_busy", busy_o[0], 0);
        chk("abort_ready", rdy[0], 1);
        chk("abort_overrun", ovr_o[0], 0);
        m_full = 1'b0;
        tx_end = e;
        q.delete();
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(1'b1, 8'hC3);
        wait_idle();

        // Even parity configuration.
        set_cfg(1, 4, 1);
        cyc(1'b1, 8'h07);
        wait_idle();
        cyc(1'b1, 8'h03);
        wait_idle();
        repeat (200) cyc($urandom_range(0, 3) == 0, 8'($urandom));
        wait_idle();

        // Minimum bit period with random traffic.
        set_cfg(2, 2, 0);
        accepted = 0;
        n = 0;
        while (accepted < 100 && n < 20000) begin
            cyc($urandom_range(0, 4) == 0, 8'($urandom));
            n++;
        end
        chk("accept_count", accepted >= 100, 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcm_uart_tx.md
PCM_UART_TX -- requirements
Module: pcm_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning system clocks per serial bit period (legal range 2..65535).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after data bit 7, 0 omits it.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  8  decoded PCM sample to transmit.
REQ-006 SHALL have port data_valid  input  1  data_in is offered this cycle.
REQ-007 SHALL have port data_ready  output  1  holding buffer empty; sample accepted when data_valid and data_ready are both high at a rising edge.
REQ-008 SHALL have port txd  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress (state not IDLE).
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a sample is offered while data_ready is low.

Function
REQ-011 SHALL contain a one-entry holding buffer (buf_data 8 bits, buf_full flag) and a separate 8-bit transmit shift register.
REQ-012 data_ready SHALL equal NOT buf_full, driven from a register.
REQ-013 On an accepting edge, buf_data SHALL load data_in and buf_full SHALL set.
REQ-014 A sample offered with data_ready low SHALL be dropped, buffer contents unchanged, and overrun SHALL be high for exactly the following cycle.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: txd=1; at an edge with buf_full=1 -> START, shift register <= buf_data, buf_full cleared, parity accumulator cleared.
REQ-017 Latency: txd SHALL go low one clock after the accepting edge when the FSM is IDLE.
REQ-018 START: txd=0 for CLKS_PER_BIT cycles, then -> DATA with bit index 0.
REQ-019 DATA: txd = shift register bit 0, LSB first; each bit held CLKS_PER_BIT cycles; shift right and increment index at bit end; after bit 7 -> PARITY if PARITY_EN=1 else STOP.
REQ-020 PARITY: txd = XOR of the 8 transmitted data bits (even parity) for CLKS_PER_BIT cycles, then -> STOP.
REQ-021 STOP: txd=1 for CLKS_PER_BIT cycles; at the end, if buf_full=1 -> START with reload per REQ-016 (no idle gap), else -> IDLE.
REQ-022 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-023 The bit-period counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, and wrap to 0 at every bit boundary.
REQ-024 The buffer SHALL accept a new sample while a frame is in progress; that sample is sent in the next frame.
REQ-025 When the buffer is loaded into the shift register at the same edge, data_ready SHALL rise on the next cycle; a same-edge offer is not accepted.
REQ-026 busy SHALL be high from the START entry edge through the last STOP cycle and low in IDLE.
REQ-027 txd, busy and overrun SHALL be driven from registers (glitch-free).

Reset
REQ-028 While reset=0: state=IDLE, txd=1, busy=0, data_ready=1, overrun=0, buf_full=0, counters and shift register=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (txd=1 asynchronously) and discard any buffered sample.
REQ-030 After reset release, the first sample SHALL be accepted at the first rising edge with data_valid=1.

Verification
REQ-031 CLKS_PER_BIT=4, PARITY_EN=0, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting 1 cycle after acceptance; busy high 40 cycles.
REQ-032 PARITY_EN=1, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
REQ-033 Offer 0x11 then 0x22 during the first frame -> two back-to-back frames, stop bit of first immediately followed by start bit of second, busy never drops.
REQ-034 Offer 0x11, 0x22, 0x33 with buffer full -> 0x33 dropped, overrun pulses exactly one cycle, only 0x11 and 0x22 appear on txd.
REQ-035 Assert reset during data bit 3 -> txd=1, busy=0, data_ready=1 with no clock; next sample transmits a complete correct frame.
REQ-036 CLKS_PER_BIT=2 (minimum), random 100 samples with random data_valid -> deserialized txd stream matches every accepted sample in order.
